// File: rtl/pkt_capture_framer.sv
`default_nettype none
// ============================================================================
// Module   : pkt_capture_framer
// Purpose  : Captures Avalon-ST frames from a MAC receive port into a payload
//            buffer and emits one record per committed frame: a header
//            (length, flags, sequence) followed by the captured payload bytes.
//            Frames are written speculatively and only become visible to the
//            reader once their eop commits them.
// Ports    : clk_clk/reset_reset                 - clock, sync active-high reset
//            rx_sink_valid/data/sop/eop/error/ready - MAC byte stream (never stalled)
//            cap_src_valid/data/sop/eop/ready     - capture record stream
//            frames_captured/frames_dropped       - saturating 16-bit counters
// Config   : CAPTURE_TIMESTAMP_EN - when defined, a 32-bit cycle counter is
//            sampled at sop and appended as header bytes 4..7 (MSB first).
// Revision : 1.0 - initial release
// ============================================================================
module pkt_capture_framer #(
  parameter int DATA_AW = 11,
  parameter int DESC_AW = 4,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        rx_sink_valid,
  input  logic [7:0]  rx_sink_data,
  input  logic        rx_sink_sop,
  input  logic        rx_sink_eop,
  input  logic [5:0]  rx_sink_error,
  output logic        rx_sink_ready,
  output logic        cap_src_valid,
  output logic [7:0]  cap_src_data,
  output logic        cap_src_sop,
  output logic        cap_src_eop,
  input  logic        cap_src_ready,
  output logic [15:0] frames_captured,
  output logic [15:0] frames_dropped
);

  localparam int DEPTH  = 1 << DATA_AW;
  localparam int DDEPTH = 1 << DESC_AW;
  localparam int PW     = DATA_AW + 1;  // pointers carry one extra wrap bit
  localparam int DW     = DESC_AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;

`ifdef CAPTURE_TIMESTAMP_EN
  localparam logic [2:0] HDR_LAST = 3'd7;
`else
  localparam logic [2:0] HDR_LAST = 3'd3;
`endif

  // Storage
  logic [7:0]    buf_mem  [DEPTH];
  logic [15:0]   dlen_mem [DDEPTH];
  logic          dtr_mem  [DDEPTH];
  logic [5:0]    derr_mem [DDEPTH];
  logic [7:0]    dseq_mem [DDEPTH];

  // Ingress state
  logic [PW-1:0] wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_q;
  logic          in_frame_q, in_frame_d, trunc_q, trunc_d, drop_q, drop_d;
  logic [15:0]   len_q, len_d;
  logic [7:0]    seq_q, seq_d;
  logic [15:0]   cap_cnt_q, cap_cnt_d, drp_cnt_q, drp_cnt_d;
  logic [DW-1:0] dwr_q, dwr_d, drd_q;

  // Ingress combinational
  logic [DW-1:0]      w_desc_cnt, w_desc_cnt2;
  logic               w_close_old, w_start, w_cur_act, w_push_old, w_drop_old;
  logic [PW-1:0]      w_base, w_pos, w_n_spec;
  logic [15:0]        w_cur_len, w_n_len;
  logic               w_cur_trunc, w_cur_drop, w_room, w_wr_en;
  logic               w_n_trunc, w_n_drop, w_end_new, w_push_new, w_drop_new;
  logic [16:0]        w_cap_sum, w_drp_sum;
  logic [DESC_AW-1:0] w_new_idx;

`ifdef CAPTURE_TIMESTAMP_EN
  logic [31:0] dts_mem [DDEPTH];
  logic [31:0] ts_q, frame_ts_q, frame_ts_d;
`endif

  always_comb begin
    w_desc_cnt  = dwr_q - drd_q;
    w_start     = rx_sink_valid & rx_sink_sop;
    w_close_old = w_start & in_frame_q;
    // Beats outside a frame without sop are ignored entirely.
    w_cur_act   = rx_sink_valid & (rx_sink_sop | in_frame_q);
    // A sop on an open frame closes it as truncated with no error flags.
    w_push_old  = w_close_old & ~drop_q & (w_desc_cnt != DW'(DDEPTH));
    w_drop_old  = w_close_old & ~w_push_old;
    w_desc_cnt2 = w_desc_cnt + DW'(w_push_old);
    // Commit point after the old frame is resolved; the new frame starts here.
    w_base      = w_push_old ? wr_spec_q : wr_commit_q;
    w_pos       = w_start ? w_base : wr_spec_q;
    w_cur_len   = w_start ? 16'd0 : len_q;
    w_cur_trunc = w_start ? 1'b0 : trunc_q;
    w_cur_drop  = w_start ? 1'b0 : drop_q;
    // Space is judged against the reader pointer, which only trails committed data.
    w_room      = ((w_pos - rd_q) != PW'(DEPTH));

    w_wr_en   = 1'b0;
    w_n_len   = w_cur_len;
    w_n_trunc = w_cur_trunc;
    w_n_drop  = w_cur_drop;
    w_n_spec  = w_pos;
    if (w_cur_act && !w_cur_drop) begin
      if (w_cur_len >= 16'(MAX_LEN)) begin
        w_n_trunc = 1'b1;
      end else if (!w_room) begin
        w_n_drop = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_n_spec = w_pos + PW'(1);
        w_n_len  = w_cur_len + 16'd1;
      end
    end

    w_end_new  = w_cur_act & rx_sink_eop;
    w_push_new = w_end_new & ~w_n_drop & (w_desc_cnt2 != DW'(DDEPTH));
    w_drop_new = w_end_new & ~w_push_new;
    w_new_idx  = dwr_q[DESC_AW-1:0] + DESC_AW'(w_push_old);

    in_frame_d  = in_frame_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    drop_d      = drop_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = w_base;
    if (w_cur_act) begin
      if (w_end_new) begin
        in_frame_d = 1'b0;
        len_d      = 16'd0;
        trunc_d    = 1'b0;
        drop_d     = 1'b0;
        // A dropped frame rewinds the speculative pointer to the last commit.
        wr_spec_d  = w_push_new ? w_n_spec : w_base;
        if (w_push_new) wr_commit_d = w_n_spec;
      end else begin
        in_frame_d = 1'b1;
        len_d      = w_n_len;
        trunc_d    = w_n_trunc;
        drop_d     = w_n_drop;
        wr_spec_d  = w_n_spec;
      end
    end

    seq_d     = seq_q + 8'(w_push_old) + 8'(w_push_new);
    dwr_d     = dwr_q + DW'(w_push_old) + DW'(w_push_new);
    w_cap_sum = {1'b0, cap_cnt_q} + 17'(w_push_old) + 17'(w_push_new);
    w_drp_sum = {1'b0, drp_cnt_q} + 17'(w_drop_old) + 17'(w_drop_new);
    cap_cnt_d = w_cap_sum[16] ? 16'hFFFF : w_cap_sum[15:0];
    drp_cnt_d = w_drp_sum[16] ? 16'hFFFF : w_drp_sum[15:0];
`ifdef CAPTURE_TIMESTAMP_EN
    frame_ts_d = w_start ? ts_q : frame_ts_q;
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      in_frame_q  <= 1'b0;
      trunc_q     <= 1'b0;
      drop_q      <= 1'b0;
      len_q       <= 16'd0;
      seq_q       <= 8'd0;
      cap_cnt_q   <= 16'd0;
      drp_cnt_q   <= 16'd0;
      dwr_q       <= '0;
`ifdef CAPTURE_TIMESTAMP_EN
      ts_q        <= 32'd0;
      frame_ts_q  <= 32'd0;
`endif
    end else begin
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      in_frame_q  <= in_frame_d;
      trunc_q     <= trunc_d;
      drop_q      <= drop_d;
      len_q       <= len_d;
      seq_q       <= seq_d;
      cap_cnt_q   <= cap_cnt_d;
      drp_cnt_q   <= drp_cnt_d;
      dwr_q       <= dwr_d;
`ifdef CAPTURE_TIMESTAMP_EN
      ts_q        <= ts_q + 32'd1;
      frame_ts_q  <= frame_ts_d;
`endif
    end
  end

  // Storage writes; up to two descriptors land in one cycle when a sop closes
  // an open frame and the new beat is itself a one-byte frame.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset) begin
      if (w_wr_en) buf_mem[w_pos[DATA_AW-1:0]] <= rx_sink_data;
      if (w_push_old) begin
        dlen_mem[dwr_q[DESC_AW-1:0]] <= len_q;
        dtr_mem[dwr_q[DESC_AW-1:0]]  <= 1'b1;
        derr_mem[dwr_q[DESC_AW-1:0]] <= 6'd0;
        dseq_mem[dwr_q[DESC_AW-1:0]] <= seq_q;
`ifdef CAPTURE_TIMESTAMP_EN
        dts_mem[dwr_q[DESC_AW-1:0]]  <= frame_ts_q;
`endif
      end
      if (w_push_new) begin
        dlen_mem[w_new_idx] <= w_n_len;
        dtr_mem[w_new_idx]  <= w_n_trunc;
        derr_mem[w_new_idx] <= rx_sink_error;
        dseq_mem[w_new_idx] <= seq_q + 8'(w_push_old);
`ifdef CAPTURE_TIMESTAMP_EN
        dts_mem[w_new_idx]  <= frame_ts_d;
`endif
      end
    end
  end

  // Egress record framer
  logic [1:0]  state_q, state_d;
  logic [2:0]  hdr_idx_q;
  logic [15:0] pay_cnt_q;
  logic [15:0] w_hlen;
  logic        w_pay_last, w_desc_empty;

  assign w_desc_empty = (dwr_q == drd_q);
  assign w_hlen       = dlen_mem[drd_q[DESC_AW-1:0]];
  assign w_pay_last   = (pay_cnt_q == w_hlen - 16'd1);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!w_desc_empty) state_d = S_HDR;
      S_HDR:   if (cap_src_ready && hdr_idx_q == HDR_LAST) state_d = S_PAY;
      S_PAY:   if (cap_src_ready && w_pay_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cap_src_valid = 1'b0;
    cap_src_data  = 8'h00;
    cap_src_sop   = 1'b0;
    cap_src_eop   = 1'b0;
    if (!reset_reset) begin
      if (state_q == S_HDR) begin
        cap_src_valid = 1'b1;
        cap_src_sop   = (hdr_idx_q == 3'd0);
        case (hdr_idx_q)
          3'd0:    cap_src_data = w_hlen[15:8];
          3'd1:    cap_src_data = w_hlen[7:0];
          3'd2:    cap_src_data = {1'b0, dtr_mem[drd_q[DESC_AW-1:0]], derr_mem[drd_q[DESC_AW-1:0]]};
          3'd3:    cap_src_data = dseq_mem[drd_q[DESC_AW-1:0]];
`ifdef CAPTURE_TIMESTAMP_EN
          3'd4:    cap_src_data = dts_mem[drd_q[DESC_AW-1:0]][31:24];
          3'd5:    cap_src_data = dts_mem[drd_q[DESC_AW-1:0]][23:16];
          3'd6:    cap_src_data = dts_mem[drd_q[DESC_AW-1:0]][15:8];
          3'd7:    cap_src_data = dts_mem[drd_q[DESC_AW-1:0]][7:0];
`endif
          default: cap_src_data = 8'h00;
        endcase
      end else if (state_q == S_PAY) begin
        cap_src_valid = 1'b1;
        cap_src_data  = buf_mem[rd_q[DATA_AW-1:0]];
        cap_src_eop   = w_pay_last;
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      hdr_idx_q <= 3'd0;
      pay_cnt_q <= 16'd0;
      rd_q      <= '0;
      drd_q     <= '0;
    end else begin
      if (state_q == S_HDR && cap_src_ready)
        hdr_idx_q <= (hdr_idx_q == HDR_LAST) ? 3'd0 : hdr_idx_q + 3'd1;
      if (state_q == S_PAY && cap_src_ready) begin
        rd_q <= rd_q + PW'(1);
        if (w_pay_last) begin
          pay_cnt_q <= 16'd0;
          drd_q     <= drd_q + DW'(1);
        end else begin
          pay_cnt_q <= pay_cnt_q + 16'd1;
        end
      end
    end
  end

  assign rx_sink_ready   = ~reset_reset;
  assign frames_captured = cap_cnt_q;
  assign frames_dropped  = drp_cnt_q;

endmodule
`default_nettype wire

// File: doc/pkt_capture_framer.md
PKT_CAPTURE_FRAMER -- requirements
Module: pkt_capture_framer

Interface
REQ-001 Parameter DATA_AW, default 11, sets payload buffer depth to 2^DATA_AW bytes.
REQ-002 Parameter DESC_AW, default 4, sets descriptor FIFO depth to 2^DESC_AW frames.
REQ-003 Parameter MAX_LEN, default 1518, sets the maximum captured bytes per frame.
REQ-004 clk_clk  in  1  sole clock; one clock, all logic rising-edge.
REQ-005 reset_reset  in  1  synchronous, active-high reset.
REQ-006 rx_sink_valid / rx_sink_data / rx_sink_sop / rx_sink_eop  in  1/8/1/1  Avalon-ST byte stream from MAC receive side.
REQ-007 rx_sink_error  in  6  MAC error flags, sampled only on the eop beat.
REQ-008 rx_sink_ready  out  1  always 1 outside reset; the block never backpressures the MAC.
REQ-009 cap_src_valid / cap_src_data / cap_src_sop / cap_src_eop  out  1/8/1/1  capture record stream.
REQ-010 cap_src_ready  in  1  downstream accept.
REQ-011 frames_captured / frames_dropped  out  16/16  saturating counters.

Function
REQ-012 Input beat accepted when rx_sink_valid=1; stored at a speculative write pointer, byte count len incremented.
REQ-013 Bytes past MAX_LEN are discarded and the frame's trunc flag is set.
REQ-014 On eop: if payload buffer never overflowed and descriptor FIFO not full, commit write pointer and push descriptor {len[15:0], trunc, error[5:0], seq[7:0]}; else rewind write pointer to last commit and increment frames_dropped.
REQ-015 Payload buffer overflow mid-frame sets a drop flag; remaining beats of that frame are discarded until eop.
REQ-016 sop while a frame is open ends the open frame as if eop arrived with trunc=1 and error=0; the sop beat starts a new frame.
REQ-017 Beats with valid=1 outside a frame and without sop are discarded and not counted.
REQ-018 seq increments on each committed frame, wrapping 255->0; frames_captured increments on each commit.
REQ-019 Error frames are captured, not dropped; error bits appear in the record.
REQ-020 Output FSM states IDLE, HDR, PAY; IDLE->HDR when descriptor FIFO non-empty; HDR->PAY after last header byte accepted; PAY->IDLE after byte len accepted.
REQ-021 Header bytes: 0=len[15:8], 1=len[7:0], 2={0,trunc,error[5:0]}, 3=seq; cap_src_sop on header byte 0, cap_src_eop on last payload byte.
REQ-022 Data, sop, eop held stable while cap_src_valid=1 and cap_src_ready=0; no bubble required between records.
REQ-023 Input-to-output latency: first header byte valid no later than 3 cycles after the commit cycle.
REQ-024 Commit and read of the same buffer in one cycle are both honoured; full/empty computed with one extra pointer wrap bit.
REQ-025 Counters saturate at 0xFFFF.

Reset
REQ-026 Reset clears pointers, FIFOs, len, seq, counters, FSM to IDLE; outputs valid/sop/eop=0, data=0, rx_sink_ready=0 during reset.
REQ-027 Reset mid-frame or mid-record discards all partial data; no record emitted for it after reset.

Configuration
REQ-028 Macro CAPTURE_TIMESTAMP_EN: when defined, a free-running 32-bit cycle counter (cleared by reset, wraps) is sampled on sop and header is 8 bytes, bytes 4..7 = timestamp MSB first; descriptor width grows accordingly.
REQ-029 Without CAPTURE_TIMESTAMP_EN: header is 4 bytes, no counter logic present.

Verification
REQ-030 64-byte frame, error=0, ready=1 -> record 00 40 00 00 then 64 payload bytes identical, frames_captured=1.
REQ-031 Frame with error=6'h02 at eop -> header byte2=0x02, payload intact.
REQ-032 1600-byte frame -> len=0x05EE, byte2=0x40, 1518 payload bytes.
REQ-033 Hold cap_src_ready=0, send frames until buffer full -> overflowing frame dropped, frames_dropped=1, earlier frames emitted intact after ready=1.
REQ-034 sop at byte 10 of open frame -> first record len=10, byte2=0x40; second frame captured with seq=1.
REQ-035 Reset asserted at byte 20 of frame, then clean 64-byte frame -> only one record, seq=0, counters 1/0.
